valid_bit_array_16: RTL
=======================

Name: valid_bit_array_16

Overview:
- 16-entry valid-bit store for a 16-line cache or tag structure.
- Sits directly upstream of the 16:1 bit-select stage: drives that stage's 16-bit data vector, and the select stage reads entry i with select = i.
- Supports per-entry set and clear, and a sequential flush that clears one entry per cycle.
- Provides a registered first-free-entry finder and a registered valid count for the allocation logic.

Parameters:
- None. The block is fixed at 16 entries with a 4-bit index, to match the downstream select stage.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- set_en  in  1  mark entry set_index valid this cycle
- set_index  in  4  entry to set
- clr_en  in  1  mark entry clr_index invalid this cycle
- clr_index  in  4  entry to clear
- flush_req  in  1  start a 16-cycle sequential flush
- valid_vec  out  16  valid bits, MSB-first: entry i is at bit [15-i]
- flush_busy  out  1  high while a flush is in progress
- free_found  out  1  at least one entry is invalid
- free_index  out  4  lowest-numbered invalid entry; 0 when free_found = 0
- valid_count  out  5  number of valid entries, 0..16

Behaviour:
- Reset (rst_n low, asynchronous): valid_vec = 16'h0000, flush_busy = 0, state = IDLE, flush pointer = 0, free_found = 1, free_index = 0, valid_count = 0.
- All outputs are registered. free_found, free_index and valid_count are computed from the next-state vector, so on every cycle they agree with valid_vec.
- Bit mapping: entry i is stored at valid_vec[15-i]. Example: entry 0 = bit 15, entry 15 = bit 0.
- State machine, 2 states: IDLE and FLUSH.
  - IDLE:
    - set_en writes entry set_index to 1 at the clock edge; clr_en writes entry clr_index to 0.
    - Both asserted with different indices: both updates apply.
    - Both asserted with the same index: set wins, and the entry ends up valid.
    - flush_req = 1: the same-cycle set/clr still applies. Next state is FLUSH, pointer = 0, and flush_busy goes high on the next cycle.
  - FLUSH:
    - Each cycle clears entry[pointer], then increments the pointer.
    - set_en, clr_en and flush_req are ignored (dropped, not queued).
    - After the cycle that clears entry 15, the pointer wraps to 0 and the state returns to IDLE. flush_busy goes low on that same edge.
- flush_busy is high for exactly 16 cycles per flush. The vector is all-zero on the first cycle that flush_busy is low.
- free_index:
  - Priority encoder over the entries, picking the lowest entry number (highest vec bit) that is 0.
  - All 16 entries valid: free_found = 0, free_index = 0.
- valid_count is the population count of the next-state vector, 5 bits wide, and never exceeds 16.
- Reset asserted mid-flush: the vector clears immediately, the state returns to IDLE, and flush_busy drops immediately (asynchronous).
- Indices are always in range (4 bits), so no out-of-range case exists.

Test Plan:
- Reset check: hold rst_n low for 3 cycles then release -> valid_vec = 0x0000, valid_count = 0, free_found = 1, free_index = 0, flush_busy = 0.
- Set entries 0, 1 and 5 on consecutive cycles -> valid_vec = 0xC400, valid_count = 3, free_index = 2. Then read the downstream select stage with select = 5 -> returns 1.
- Set and clear collisions:
  - set_en = clr_en = 1 with both indices 7 -> entry 7 valid (bit 8 set).
  - Same cycle with set_index = 3, clr_index = 0 (entry 0 previously valid) -> bit 12 set, bit 15 clear.
- Fill all 16 entries -> valid_vec = 0xFFFF, valid_count = 16, free_found = 0, free_index = 0. Then clear entry 9 -> free_index = 9, valid_count = 15.
- Flush from 0xFFFF:
  - Assert flush_req for 1 cycle -> flush_busy is high for 16 cycles, and valid_count decrements by 1 per cycle from 15 to 0.
  - A set_en of entry 2 issued mid-flush is dropped.
  - Final valid_vec = 0x0000.
  - A flush_req at cycle 8 of the flush does not extend it.
- Start a flush from 0xFFFF, then pulse rst_n low at flush cycle 6 -> valid_vec = 0, flush_busy = 0 asynchronously. After release, the block sits in IDLE and accepts set_en on the first cycle.

Source files
------------

// File: rtl/valid_bit_array_16.sv
// valid_bit_array_16: 16-entry valid-bit store with per-entry set/clear,
// a 16-cycle sequential flush, and registered free-entry finder/valid count.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   set_en/set_index      mark an entry valid
//   clr_en/clr_index      mark an entry invalid
//   flush_req             start a sequential flush (one entry per cycle)
//   valid_vec[15:0]       entry i at bit [15-i]
//   flush_busy            flush in progress
//   free_found/free_index lowest invalid entry (0 when none)
//   valid_count[4:0]      number of valid entries
module valid_bit_array_16 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       set_en,
   input  logic [3:0] set_index,
   input  logic       clr_en,
   input  logic [3:0] clr_index,
   input  logic       flush_req,
   output logic [15:0] valid_vec,
   output logic       flush_busy,
   output logic       free_found,
   output logic [3:0] free_index,
   output logic [4:0] valid_count
);

   typedef enum logic {IDLE, FLUSH} state_t;

   state_t      state_q, state_d;
   logic [3:0]  ptr_q, ptr_d;
   logic [15:0] vec_d;
   logic        ff_d;
   logic [3:0]  fi_d;
   logic [4:0]  cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= 4'd0;
         valid_vec   <= 16'h0000;
         free_found  <= 1'b1;
         free_index  <= 4'd0;
         valid_count <= 5'd0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         valid_vec   <= vec_d;
         free_found  <= ff_d;
         free_index  <= fi_d;
         valid_count <= cnt_d;
      end
   end

   assign flush_busy = (state_q == FLUSH);

   // Entry i lives at bit 15-i, i.e. bit ~i for a 4-bit index.
   // Clear is applied before set so a same-index collision leaves it valid.
   always_comb begin
      vec_d   = valid_vec;
      state_d = state_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         IDLE: begin
            if (clr_en) vec_d[~clr_index] = 1'b0;
            if (set_en) vec_d[~set_index] = 1'b1;
            if (flush_req) begin
               state_d = FLUSH;
               ptr_d   = 4'd0;
            end
         end
         FLUSH: begin
            vec_d[~ptr_q] = 1'b0;
            ptr_d = 4'(ptr_q + 4'd1);
            if (ptr_q == 4'd15) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            ptr_d   = 4'd0;
         end
      endcase
   end

   // Scan from entry 15 down so the lowest free entry is written last.
   always_comb begin
      ff_d = 1'b0;
      fi_d = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (!vec_d[~4'(i)]) begin
            ff_d = 1'b1;
            fi_d = 4'(i);
         end
      end
   end

   always_comb begin
      cnt_d = 5'd0;
      for (int i = 0; i < 16; i++) begin
         cnt_d = cnt_d + {4'd0, vec_d[i]};
      end
   end

endmodule
